// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory-port arbiters.
//   - MEM_ARB_MAX_REQ : largest supported number of masters.
//   - arb_ptr_t       : priority-pointer type wide enough for MEM_ARB_MAX_REQ.
//   - arb_vec_t       : request/grant vector type of MEM_ARB_MAX_REQ bits.
//   - rr_pick()       : behavioural round-robin pick returning a one-hot winner.
//   Also provides a fallback definition of XLEN for standalone builds.

`ifndef XLEN
`define XLEN 32
`endif

package mem_arb_pkg;

  localparam int MEM_ARB_MAX_REQ = 8;
  localparam int MEM_ARB_PTR_W   = $clog2(MEM_ARB_MAX_REQ);

  typedef logic [MEM_ARB_PTR_W-1:0]   arb_ptr_t;
  typedef logic [MEM_ARB_MAX_REQ-1:0] arb_vec_t;

  // First set bit of req scanning ptr, ptr+1, ... modulo MEM_ARB_MAX_REQ.
  // Callers with fewer than MEM_ARB_MAX_REQ masters leave the unused upper
  // request bits at zero and keep ptr below their master count; the unused
  // positions are then skipped, so the scan order equals modulo their count.
  function automatic arb_vec_t rr_pick(input arb_vec_t req, input arb_ptr_t ptr);
    arb_vec_t grant;
    arb_ptr_t idx;
    logic     found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MEM_ARB_MAX_REQ; k++) begin
      idx = ptr + arb_ptr_t'(k);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker
//   Purely combinational round-robin picker: rotates the request vector so
//   that position ptr becomes bit 0, isolates the lowest set bit, and rotates
//   the result back.
//   Ports:
//     req   [N-1:0]  request vector
//     ptr   [PW-1:0] highest-priority position (must be < N)
//     grant [N-1:0]  one-hot winner, zero when req is zero

module rr_priority_picker #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] pick_dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   pick;

  always_comb begin
    // Duplicating the vector turns a rotate into a plain shift.
    req_dbl  = {req, req};
    rot      = N'(req_dbl >> ptr);
    // x & -x keeps only the lowest set bit.
    pick     = rot & (~rot + N'(1));
    pick_dbl = {pick, pick};
    grant    = N'((pick_dbl << ptr) >> N);
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
//   Shares one memory port (req/we/addr/wdata -> rdata/ready) between NUM_REQ
//   masters. Round-robin priority with a back-to-back burst allowance of
//   BURST_MAX completions for the master holding top priority. A grant that
//   is not acknowledged in its cycle is locked so the winner stays stable
//   until the slave raises ready. The data path is zero latency: grant, mux
//   and ready all act in the same cycle.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     m_mem_req/we   [NUM_REQ]   per-master request / write enable
//     m_mem_addr     [NUM_REQ*AW] packed, master i at [i*AW +: AW]
//     m_mem_wdata    [NUM_REQ*DW] packed, master i at [i*DW +: DW]
//     m_mem_rdata    [DW]        slave read data broadcast to all masters
//     m_mem_ready    [NUM_REQ]   per-master ready (grant & s_mem_ready)
//     m_grant        [NUM_REQ]   one-hot grant, zero when idle
//     s_mem_*                    downstream port

module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int BURST_MAX = 4,
  parameter int AW        = `XLEN,
  parameter int DW        = `XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    m_mem_req,
  input  logic [NUM_REQ-1:0]    m_mem_we,
  input  logic [NUM_REQ*AW-1:0] m_mem_addr,
  input  logic [NUM_REQ*DW-1:0] m_mem_wdata,
  output logic [DW-1:0]         m_mem_rdata,
  output logic [NUM_REQ-1:0]    m_mem_ready,
  output logic [NUM_REQ-1:0]    m_grant,
  output logic                  s_mem_req,
  output logic                  s_mem_we,
  output logic [AW-1:0]         s_mem_addr,
  output logic [DW-1:0]         s_mem_wdata,
  input  logic [DW-1:0]         s_mem_rdata,
  input  logic                  s_mem_ready
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);

  logic [PW-1:0] rr_ptr_q,    rr_ptr_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          locked_q,    locked_d;
  logic [PW-1:0] lock_id_q,   lock_id_d;

  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] lock_onehot;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      grant_idx;
  logic [PW-1:0]      grant_idx_inc;
  logic               completion;

  logic [AW-1:0] addr_arr  [NUM_REQ];
  logic [DW-1:0] wdata_arr [NUM_REQ];

  rr_priority_picker #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_picker (
    .req   (m_mem_req),
    .ptr   (rr_ptr_q),
    .grant (pick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]    = m_mem_addr[gi*AW +: AW];
      assign wdata_arr[gi]   = m_mem_wdata[gi*DW +: DW];
      assign lock_onehot[gi] = (lock_id_q == PW'(gi));
    end
  endgenerate

  // Gated by rst_n so the grant (and everything derived from it) drops the
  // instant reset is asserted, not just at the next edge.
  always_comb begin
    grant = '0;
    if (rst_n) begin
      grant = locked_q ? lock_onehot : pick;
    end
  end

  // One-hot mux; fields are zero when nothing is granted.
  always_comb begin
    grant_idx   = '0;
    s_mem_addr  = '0;
    s_mem_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx   = PW'(i);
        s_mem_addr  = addr_arr[i];
        s_mem_wdata = wdata_arr[i];
      end
    end
  end

  assign s_mem_req     = |(m_mem_req & grant);
  assign s_mem_we      = |(m_mem_we & grant);
  assign m_mem_ready   = grant & {NUM_REQ{s_mem_ready}};
  assign m_mem_rdata   = s_mem_rdata;
  assign m_grant       = grant;
  assign completion    = s_mem_req & s_mem_ready;

  // Explicit wrap so non-power-of-two counts go NUM_REQ-1 -> 0.
  assign grant_idx_inc = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    locked_d    = locked_q;
    lock_id_d   = lock_id_q;

    if (completion) begin
      locked_d = 1'b0;
      if (grant_idx == rr_ptr_q) begin
        if (burst_cnt_q < BW'(BURST_MAX - 1)) begin
          burst_cnt_d = burst_cnt_q + BW'(1);
        end else begin
          rr_ptr_d    = grant_idx_inc;
          burst_cnt_d = '0;
        end
      end else if (BURST_MAX > 1) begin
        // A lower-priority winner takes over top priority and has already
        // used one slot of its burst.
        rr_ptr_d    = grant_idx;
        burst_cnt_d = BW'(1);
      end else begin
        rr_ptr_d    = grant_idx_inc;
        burst_cnt_d = '0;
      end
    end else if (s_mem_req) begin
      // Slave stalled: freeze the winner until ready.
      locked_d  = 1'b1;
      lock_id_d = grant_idx;
    end else if (locked_q) begin
      // Locked master withdrew its request: release, nothing counted.
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      locked_q    <= 1'b0;
      lock_id_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      locked_q    <= locked_d;
      lock_id_q   <= lock_id_d;
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter
//   Directed and random stimulus for mem_rr_arbiter with three masters and a
//   burst allowance of three, in front of a zero-latency memory whose ready
//   follows req unless the bench stalls it.

module tb_mem_rr_arbiter;

  localparam int N  = 3;
  localparam int BM = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_v;
  logic [N-1:0]    we_v;
  logic [AW-1:0]   addr_v [N];
  logic [DW-1:0]   wd_v   [N];
  logic [N*AW-1:0] m_mem_addr;
  logic [N*DW-1:0] m_mem_wdata;

  logic [DW-1:0] m_mem_rdata;
  logic [N-1:0]  m_mem_ready;
  logic [N-1:0]  m_grant;
  logic          s_mem_req;
  logic          s_mem_we;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_mem_wdata;
  logic [DW-1:0] s_mem_rdata;
  logic          s_mem_ready;

  logic          stall;
  logic          mem_clear;
  logic [DW-1:0] mem [256];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pack
      assign m_mem_addr[gi*AW +: AW]  = addr_v[gi];
      assign m_mem_wdata[gi*DW +: DW] = wd_v[gi];
    end
  endgenerate

  // Zero-latency memory slave: ready follows req unless stalled.
  assign s_mem_ready = s_mem_req & ~stall;
  assign s_mem_rdata = mem[s_mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (s_mem_req && s_mem_ready && s_mem_we) begin
      mem[s_mem_addr[9:2]] <= s_mem_wdata;
    end
  end

  mem_rr_arbiter #(
    .NUM_REQ   (N),
    .BURST_MAX (BM),
    .AW        (AW),
    .DW        (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_mem_req   (req_v),
    .m_mem_we    (we_v),
    .m_mem_addr  (m_mem_addr),
    .m_mem_wdata (m_mem_wdata),
    .m_mem_rdata (m_mem_rdata),
    .m_mem_ready (m_mem_ready),
    .m_grant     (m_grant),
    .s_mem_req   (s_mem_req),
    .s_mem_we    (s_mem_we),
    .s_mem_addr  (s_mem_addr),
    .s_mem_wdata (s_mem_wdata),
    .s_mem_rdata (s_mem_rdata),
    .s_mem_ready (s_mem_ready)
  );

  // Reference model state: priority holder, completions it has used in its
  // current run, and the locked master (-1 = none).
  int m_ptr, m_cnt, m_lock, w;
  int n_checks, n_fail;

  logic [N-1:0]  e_grant, e_ready;
  logic          e_sreq, e_sready, e_we;
  logic [31:0]   e_addr, e_wd, e_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    if (!rst_n) begin
      m_ptr  = 0;
      m_cnt  = 0;
      m_lock = -1;
    end
    w = -1;
    if (rst_n) begin
      if (m_lock >= 0) w = m_lock;
      else begin
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req_v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
      end
    end
    e_grant = '0;
    e_sreq  = 1'b0;
    e_we    = 1'b0;
    e_addr  = '0;
    e_wd    = '0;
    if (w >= 0) begin
      e_grant[w] = 1'b1;
      e_sreq     = req_v[w];
      e_we       = we_v[w];
      e_addr     = addr_v[w];
      e_wd       = wd_v[w];
    end
    e_sready = e_sreq && !stall;
    e_ready  = e_sready ? e_grant : '0;
    e_rdata  = mem[e_addr[9:2]];
  endtask

  task automatic model_commit();
    if (rst_n) begin
      if (e_sreq && e_sready) begin
        m_lock = -1;
        if (w == m_ptr) begin
          if (m_cnt < BM - 1) m_cnt++;
          else begin
            m_ptr = (w + 1) % N;
            m_cnt = 0;
          end
        end else if (BM > 1) begin
          m_ptr = w;
          m_cnt = 1;
        end else begin
          m_ptr = (w + 1) % N;
          m_cnt = 0;
        end
      end else if (e_sreq) begin
        m_lock = w;
      end else if (m_lock >= 0) begin
        m_lock = -1;
      end
    end
  endtask

  // Called at a falling edge after inputs are set; checks mid-cycle.
  task automatic check_cycle(input string tag);
    #2;
    model_eval();
    $display("%-10s req=%b grant=%b s_req=%b we=%b addr=%h wdata=%h ready=%b rdata=%h",
             tag, req_v, m_grant, s_mem_req, s_mem_we, s_mem_addr, s_mem_wdata,
             m_mem_ready, m_mem_rdata);
    chk({tag, ".grant"}, 32'(m_grant),     32'(e_grant));
    chk({tag, ".s_req"}, 32'(s_mem_req),   32'(e_sreq));
    chk({tag, ".s_we"},  32'(s_mem_we),    32'(e_we));
    chk({tag, ".s_addr"}, s_mem_addr,      e_addr);
    chk({tag, ".s_wdata"}, s_mem_wdata,    e_wd);
    chk({tag, ".ready"}, 32'(m_mem_ready), 32'(e_ready));
    chk({tag, ".rdata"}, m_mem_rdata,      e_rdata);
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic cycle(input string tag);
    check_cycle(tag);
    advance();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_ptr     = 0;
    m_cnt     = 0;
    m_lock    = -1;
    rst_n     = 1'b0;
    stall     = 1'b0;
    mem_clear = 1'b1;
    req_v     = '0;
    we_v      = '0;
    for (int i = 0; i < N; i++) begin
      addr_v[i] = '0;
      wd_v[i]   = '0;
    end
    @(negedge clk);

    // Outputs stay idle in reset even with requests present.
    req_v = '1;
    cycle("reset");
    check_cycle("reset");
    chk("reset.grant_zero", 32'(m_grant), 32'd0);
    advance();
    mem_clear = 1'b0;
    rst_n     = 1'b1;

    // Back-to-back bursts between masters 0 and 1.
    req_v     = 3'b011;
    addr_v[0] = 32'h10;
    addr_v[1] = 32'h20;
    repeat (10) cycle("burst");

    // Stalled write from master 0; master 1 arrives while locked.
    req_v     = 3'b001;
    we_v      = 3'b001;
    addr_v[0] = 32'h40;
    wd_v[0]   = 32'hDEADBEEF;
    addr_v[1] = 32'h40;
    stall     = 1'b1;
    cycle("stall0");
    req_v[1] = 1'b1;
    check_cycle("stall1");
    chk("stall1.locked_grant", 32'(m_grant), 32'h1);
    chk("stall1.locked_addr", s_mem_addr, 32'h40);
    advance();
    cycle("stall2");
    stall = 1'b0;
    cycle("stall_done");
    req_v[0] = 1'b0;
    we_v     = '0;
    check_cycle("m1_after");
    chk("m1_after.grant", 32'(m_grant), 32'h2);
    chk("m1_after.rdata", m_mem_rdata, 32'hDEADBEEF);
    advance();

    // Lone master 2, then everyone: pointer wrap.
    req_v = 3'b100;
    cycle("wrap_m2");
    req_v = 3'b111;
    repeat (9) cycle("wrap_all");

    // Locked master withdraws its request.
    req_v = 3'b100;
    stall = 1'b1;
    cycle("drop_lock");
    req_v = 3'b000;
    cycle("drop_req");
    stall = 1'b0;
    req_v = 3'b011;
    cycle("drop_after");

    // Reset in the middle of a locked transaction.
    req_v = 3'b110;
    stall = 1'b1;
    cycle("lock_rst");
    req_v = 3'b111;
    rst_n = 1'b0;
    check_cycle("rst_mid");
    chk("rst_mid.grant_zero", 32'(m_grant), 32'd0);
    chk("rst_mid.sreq_zero", 32'(s_mem_req), 32'd0);
    advance();
    rst_n = 1'b1;
    stall = 1'b0;
    check_cycle("post_rst");
    chk("post_rst.grant_m0", 32'(m_grant), 32'h1);
    advance();

    // Preload word 0x40, then master 1 reads byte address 0x100.
    req_v     = 3'b001;
    we_v      = 3'b001;
    addr_v[0] = 32'h100;
    wd_v[0]   = 32'h12345678;
    cycle("preload");
    req_v     = 3'b010;
    we_v      = '0;
    addr_v[1] = 32'h100;
    check_cycle("read100");
    chk("read100.rdata", m_mem_rdata, 32'h12345678);
    chk("read100.ready", 32'(m_mem_ready), 32'h2);
    advance();

    // Random traffic; a locked master keeps its fields, rarely drops req.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (i == m_lock) begin
          if ($urandom_range(0, 15) == 0) req_v[i] = 1'b0;
        end else begin
          req_v[i]  = ($urandom_range(0, 9) < 6);
          we_v[i]   = 1'($urandom_range(0, 1));
          addr_v[i] = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          wd_v[i]   = $urandom;
        end
      end
      stall = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
